pwm_multi_gen: RTL



---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_chan.sv | 38 +++
 rtl/pwm_multi_gen.sv | 101 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM generator.
package pwm_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;

    typedef enum logic {
        PWM_EDGE,
        PWM_CENTER
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } cnt_dir_e;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: staged/active duty, comparator against the shared counter, output flop.
module pwm_chan
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ena,
    input  logic             i_stage_we,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_duty,
    input  logic [WIDTH-1:0] i_cnt,
    output logic             o_pwm
);

    logic [WIDTH-1:0] r_stg_duty;
    logic [WIDTH-1:0] r_act_duty;
    logic [WIDTH-1:0] w_stg_next;

    // A write landing in the update cycle goes straight through to active.
    assign w_stg_next = i_stage_we ? i_duty : r_stg_duty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stg_duty <= '0;
            r_act_duty <= '0;
            o_pwm      <= 1'b0;
        end else begin
            r_stg_duty <= w_stg_next;
            if (i_load) begin
                r_act_duty <= w_stg_next;
            end
            o_pwm <= i_ena && (i_cnt < r_act_duty);
        end
    end

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: one shared up / up-down period counter, per-channel duty,
// all settings double-buffered and applied only at the period boundary.
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          period_i,
    input  logic [CHANNELS*WIDTH-1:0] duty_i,
    input  logic                      center_i,
    output logic [CHANNELS-1:0]       pwm_o,
    output logic                      period_end_o
);

    logic [WIDTH-1:0] r_cnt;
    cnt_dir_e         r_dir;
    logic [WIDTH-1:0] r_stg_period;
    logic [WIDTH-1:0] r_act_period;
    pwm_mode_e        r_stg_mode;
    pwm_mode_e        r_act_mode;
    logic             r_started;

    logic [WIDTH-1:0] w_stg_period;
    pwm_mode_e        w_stg_mode;
    logic             w_last;
    logic             w_load;

    assign w_stg_period = wr_en ? period_i : r_stg_period;
    assign w_stg_mode   = wr_en ? (center_i ? PWM_CENTER : PWM_EDGE) : r_stg_mode;

    always_comb begin
        w_last = 1'b0;
        if (r_act_period == '0) begin
            w_last = 1'b1;
        end else if (r_act_mode == PWM_EDGE) begin
            w_last = (r_cnt == r_act_period);
        end else begin
            w_last = (r_cnt == WIDTH'(1)) && ((r_dir == DIR_DOWN) || (r_act_period == WIDTH'(1)));
        end
    end

    // r_started keeps the first cycle after reset from counting as an update cycle.
    assign w_load       = ena && r_started && w_last;
    assign period_end_o = w_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_dir        <= DIR_UP;
            r_stg_period <= '0;
            r_act_period <= '0;
            r_stg_mode   <= PWM_EDGE;
            r_act_mode   <= PWM_EDGE;
            r_started    <= 1'b0;
        end else begin
            r_started    <= 1'b1;
            r_stg_period <= w_stg_period;
            r_stg_mode   <= w_stg_mode;
            if (w_load) begin
                r_act_period <= w_stg_period;
                r_act_mode   <= w_stg_mode;
            end
            if (ena) begin
                if (w_last) begin
                    r_cnt <= '0;
                    r_dir <= DIR_UP;
                end else if (r_act_mode == PWM_EDGE) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (r_dir == DIR_UP) begin
                    if (r_cnt == r_act_period) begin
                        r_dir <= DIR_DOWN;
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        pwm_chan #(.WIDTH(WIDTH)) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_ena      (ena),
            .i_stage_we (wr_en),
            .i_load     (w_load),
            .i_duty     (duty_i[k*WIDTH +: WIDTH]),
            .i_cnt      (r_cnt),
            .o_pwm      (pwm_o[k])
        );
    end

endmodule
